// File: rtl/alu_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module  : alu_operand_fetch
// Brief   : Operand-fetch/issue stage ahead of the ALU. 16x32 register file,
//           EX/WB forwarding, registered valid/ready output to the ALU.
// Revision: 1.0 - initial release
// ============================================================================
module alu_operand_fetch #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [3:0]        in_shift,
    input  logic [ADDR_W-1:0] in_ra1,
    input  logic [ADDR_W-1:0] in_ra2,
    input  logic [ADDR_W-1:0] in_wa,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              ex_fwd_en,
    input  logic [ADDR_W-1:0] ex_fwd_wa,
    input  logic [DATA_W-1:0] ex_fwd_wd,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] sr1,
    output logic [DATA_W-1:0] sr2,
    output logic [2:0]        os,
    output logic [3:0]        shift,
    output logic [ADDR_W-1:0] out_wa
);

    localparam logic [ADDR_W-1:0] c_ZERO_IDX = '0;

    logic [DATA_W-1:0] r_regs [REG_N];
    logic              r_valid;
    logic [DATA_W-1:0] r_sr1;
    logic [DATA_W-1:0] r_sr2;
    logic [2:0]        r_os;
    logic [3:0]        r_shift;
    logic [ADDR_W-1:0] r_wa;

    logic              w_capture;
    logic              w_wb_write;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2_reg;
    logic [DATA_W-1:0] w_op2;

    assign in_ready   = ~r_valid | out_ready;
    assign w_capture  = in_valid & in_ready & ~flush;
    assign w_wb_write = wb_we && (wb_wa != c_ZERO_IDX);

    // r0 has no storage; it always reads as zero
    assign r_regs[0] = '0;

    for (genvar gi = 1; gi < REG_N; gi++) begin : g_regfile
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_regs[gi] <= '0;
            end else if (w_wb_write && (wb_wa == ADDR_W'(gi))) begin
                r_regs[gi] <= wb_wd;
            end
        end
    end

    // EX result is younger than WB data, so it wins when both target the index
    always_comb begin
        w_op1 = r_regs[in_ra1];
        if (in_ra1 == c_ZERO_IDX) begin
            w_op1 = '0;
        end else if (ex_fwd_en && (ex_fwd_wa == in_ra1)) begin
            w_op1 = ex_fwd_wd;
        end else if (wb_we && (wb_wa == in_ra1)) begin
            w_op1 = wb_wd;
        end
    end

    always_comb begin
        w_op2_reg = r_regs[in_ra2];
        if (in_ra2 == c_ZERO_IDX) begin
            w_op2_reg = '0;
        end else if (ex_fwd_en && (ex_fwd_wa == in_ra2)) begin
            w_op2_reg = ex_fwd_wd;
        end else if (wb_we && (wb_wa == in_ra2)) begin
            w_op2_reg = wb_wd;
        end
    end

    assign w_op2 = in_use_imm ? in_imm : w_op2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload only moves on capture, so a stall holds it bit-stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr1   <= '0;
            r_sr2   <= '0;
            r_os    <= '0;
            r_shift <= '0;
            r_wa    <= '0;
        end else if (w_capture) begin
            r_sr1   <= w_op1;
            r_sr2   <= w_op2;
            r_os    <= in_op;
            r_shift <= in_shift;
            r_wa    <= in_wa;
        end
    end

    assign out_valid = r_valid;
    assign sr1       = r_sr1;
    assign sr2       = r_sr2;
    assign os        = r_os;
    assign shift     = r_shift;
    assign out_wa    = r_wa;

endmodule
`default_nettype wire
